// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 8-bit CPU datapath.
// Latches the fetched instruction into ir, decodes its opcode (ir[7:4]) and
// walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
// The datapath strobes are combinational from state and ir, so reset
// silences them at once, without waiting for a clock edge.
// The only handshake is run: the next instruction byte is taken on a
// rising clk edge in FETCH when run=1. With run=0 the unit waits in FETCH
// and ir is left unchanged. No other flow control exists.
// All state is reported on state_out for debug and checker binding.
module control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [7:0]       instruction,
  input  logic             zero,
  output logic             reg_write,
  output logic             mem_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             jump,
  output logic [3:0]       alu_op,
  output logic             pc_en,
  output logic             halted,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Opcodes (ir[7:4])
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_SHL   = 4'hA;
  localparam logic [3:0] OP_SHR   = 4'hB;
  localparam logic [3:0] OP_MOV   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_JZ    = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t           r_state;
  logic [7:0]       r_ir;
  logic             r_z_flag;
  logic [CNT_W-1:0] r_instr_count;

  logic [3:0] w_opc;
  logic       w_is_nop;
  logic       w_is_alu;
  logic       w_is_imm;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_jmp;
  logic       w_is_jz;
  logic       w_is_halt;
  logic [3:0] w_alu_op;
  logic       w_alu_phase;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_mem_to_reg;
  logic       w_jump;
  logic       w_pc_en;
  logic       w_unused_ok;

  assign w_opc = r_ir[7:4];

  // The low nibble is an operand for the datapath; this unit only decodes.
  assign w_unused_ok = ^r_ir[3:0];

  // Opcode class decode and ALU operation lookup.
  always_comb begin
    w_is_nop   = (w_opc == OP_NOP);
    w_is_load  = (w_opc == OP_LOAD);
    w_is_store = (w_opc == OP_STORE);
    w_is_jmp   = (w_opc == OP_JMP);
    w_is_jz    = (w_opc == OP_JZ);
    w_is_halt  = (w_opc == OP_HALT);
    w_is_imm   = (w_opc == OP_ADDI) || (w_opc == OP_SUBI) ||
                 w_is_load || w_is_store;
    w_is_alu   = ((w_opc >= OP_ADD) && (w_opc <= OP_SUBI)) ||
                 ((w_opc >= OP_SHL) && (w_opc <= OP_MOV));
    w_alu_op   = 4'b0000;
    case (w_opc)
      OP_SUB, OP_SUBI: w_alu_op = 4'b0001;
      OP_AND:          w_alu_op = 4'b0010;
      OP_OR:           w_alu_op = 4'b0011;
      OP_XOR:          w_alu_op = 4'b0100;
      OP_SHL:          w_alu_op = 4'b0101;
      OP_SHR:          w_alu_op = 4'b0110;
      OP_MOV:          w_alu_op = 4'b0111;
      default:         w_alu_op = 4'b0000;
    endcase
  end

  // Datapath strobes from current state and ir; one strobe-owning state each.
  always_comb begin
    w_alu_phase  = (r_state == S_EXECUTE) || (r_state == S_MEMORY) ||
                   (r_state == S_WRITEBACK);
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_jump       = 1'b0;
    w_pc_en      = 1'b0;
    case (r_state)
      S_DECODE: begin
        w_pc_en = w_is_nop;
      end
      S_EXECUTE: begin
        if (w_is_jmp) begin
          w_jump  = 1'b1;
          w_pc_en = 1'b1;
        end else if (w_is_jz) begin
          w_jump  = r_z_flag;
          w_pc_en = 1'b1;
        end
      end
      S_MEMORY: begin
        if (w_is_load) begin
          w_mem_to_reg = 1'b1;
        end else if (w_is_store) begin
          w_mem_write = 1'b1;
          w_pc_en     = 1'b1;
        end
      end
      S_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_pc_en      = 1'b1;
        w_mem_to_reg = w_is_load;
      end
      default: begin
        w_pc_en = 1'b0;
      end
    endcase
  end

  assign reg_write   = w_reg_write;
  assign mem_write   = w_mem_write;
  assign mem_to_reg  = w_mem_to_reg;
  assign jump        = w_jump;
  assign pc_en       = w_pc_en;
  assign alu_op      = w_alu_phase ? w_alu_op : 4'b0000;
  assign alu_src     = w_alu_phase & w_is_imm;
  assign halted      = (r_state == S_HALT);
  assign state_out   = r_state;
  assign instr_count = r_instr_count;

  // Sequencer: state, instruction register, zero flag and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_ir          <= 8'h00;
      r_z_flag      <= 1'b0;
      r_instr_count <= '0;
    end else begin
      if (w_pc_en) begin
        r_instr_count <= r_instr_count + CNT_ONE;
      end
      case (r_state)
        S_FETCH: begin
          if (run) begin
            r_ir    <= instruction;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_is_nop) begin
            r_state <= S_FETCH;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (w_is_alu) begin
            r_state <= S_WRITEBACK;
          end else if (w_is_load || w_is_store) begin
            r_state <= S_MEMORY;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEMORY: begin
          r_state <= w_is_load ? S_WRITEBACK : S_FETCH;
        end
        S_WRITEBACK: begin
          if (w_is_alu) begin
            r_z_flag <= zero;
          end
          r_state <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
